// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage of the philosophy_v core. Walks a sequential fetch PC, issues
// reads to a synchronous instruction memory (one-cycle read latency), and
// buffers each returned {pc, instruction} pair in a small prefetch FIFO that
// the decode stage drains. A redirect from execute flushes the FIFO, drops
// any read in flight and restarts fetch at the (word-aligned) target.
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   rstb           asynchronous active-low reset
//   imem_rd_ena    read request to instruction memory
//   imem_addr      read address (always the fetch PC register)
//   imem_rd_data   read data, valid one cycle after imem_rd_ena
//   redirect_valid flush and restart fetch at redirect_pc
//   redirect_pc    redirect target address
//   instr_valid    FIFO head valid
//   instr_ready    decode accepts the head
//   instr          head instruction (0 while instr_valid is low)
//   instr_pc       head instruction address (0 while instr_valid is low)
//   fifo_count     number of occupied FIFO entries
//   misalign_err   sticky flag: a redirect target had nonzero bits [1:0]
//
// Decode handshake: the head transfers on a rising edge where instr_valid
// and instr_ready are both high. instr_valid never depends on instr_ready,
// and while instr_ready is low the head (instr_valid, instr, instr_pc)
// stays stable unless a redirect flushes the FIFO.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                   BUS_WIDTH  = 32,
    parameter int                   FIFO_DEPTH = 4,
    parameter logic [BUS_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          rstb,
    output logic                          imem_rd_ena,
    output logic [BUS_WIDTH-1:0]          imem_addr,
    input  logic [31:0]                   imem_rd_data,
    input  logic                          redirect_valid,
    input  logic [BUS_WIDTH-1:0]          redirect_pc,
    output logic                          instr_valid,
    input  logic                          instr_ready,
    output logic [31:0]                   instr,
    output logic [BUS_WIDTH-1:0]          instr_pc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          misalign_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [BUS_WIDTH-1:0] fpc;
    logic [BUS_WIDTH-1:0] rsp_pc;
    logic                 infl;
    logic                 sq;
    logic [AW-1:0]        rd_ptr;
    logic [AW-1:0]        wr_ptr;
    logic [CW-1:0]        count;

    logic [BUS_WIDTH-1:0] pc_mem   [FIFO_DEPTH];
    logic [31:0]          data_mem [FIFO_DEPTH];

    logic [CW:0]          occupancy;
    logic                 issue;
    logic                 push;
    logic                 pop;

    // Reserve a slot for the read in flight; a pop this cycle is not
    // credited, which keeps the issue path free of decode timing.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, infl};
    assign issue     = rstb && !redirect_valid
                       && (occupancy < (CW+1)'(FIFO_DEPTH));

    // Data returning this cycle belongs to the read issued last cycle.
    assign push = infl && !sq && !redirect_valid;
    assign pop  = instr_valid && instr_ready;

    assign imem_rd_ena = issue;
    assign imem_addr   = fpc;
    assign fifo_count  = count;
    assign instr_valid = (count != '0);

    // Gate the head with valid so stale RAM contents never show after
    // reset or a flush.
    assign instr    = instr_valid ? data_mem[rd_ptr] : 32'h0;
    assign instr_pc = instr_valid ? pc_mem[rd_ptr]   : '0;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            fpc          <= RESET_PC;
            rsp_pc       <= '0;
            infl         <= 1'b0;
            sq           <= 1'b0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            misalign_err <= 1'b0;
        end else begin
            infl <= issue;
            if (issue) begin
                rsp_pc <= fpc;
            end

            if (redirect_valid) begin
                fpc    <= {redirect_pc[BUS_WIDTH-1:2], 2'b00};
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                // Mark a read that was in flight so its data is dropped.
                sq     <= infl;
                if (redirect_pc[1:0] != 2'b00) begin
                    misalign_err <= 1'b1;
                end
            end else begin
                sq <= 1'b0;
                if (issue) begin
                    fpc <= fpc + BUS_WIDTH'(4);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= rsp_pc;
            data_mem[wr_ptr] <= imem_rd_data;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Bench for instr_fetch_unit. Two instances share the clock: "dut" with
// RESET_PC = 0 for the main scenarios and "dut_w" with RESET_PC =
// 0xFFFF_FFF8 for the address-wrap and asynchronous-reset scenario. Each has
// a one-cycle-latency memory model returning addr ^ 0xA5A5_0000. Expected
// PCs are pushed onto exp_q when stimulus is applied and popped on every
// decode handshake. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam logic [31:0] K       = 32'hA5A5_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstb, rd_ena, redir_v, ivalid, iready, merr;
  logic [31:0] addr, rd_data, redir_pc, instr, ipc;
  logic [2:0]  fcount;

  logic        rstb_w, rd_ena_w, ivalid_w, iready_w, merr_w;
  logic [31:0] addr_w, rd_data_w, instr_w, ipc_w;
  logic [2:0]  fcount_w;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  instr_fetch_unit #(.BUS_WIDTH(32), .FIFO_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rstb(rstb), .imem_rd_ena(rd_ena), .imem_addr(addr),
    .imem_rd_data(rd_data), .redirect_valid(redir_v), .redirect_pc(redir_pc),
    .instr_valid(ivalid), .instr_ready(iready), .instr(instr), .instr_pc(ipc),
    .fifo_count(fcount), .misalign_err(merr)
  );

  instr_fetch_unit #(.BUS_WIDTH(32), .FIFO_DEPTH(4), .RESET_PC(WRAP_PC)) dut_w (
    .clk(clk), .rstb(rstb_w), .imem_rd_ena(rd_ena_w), .imem_addr(addr_w),
    .imem_rd_data(rd_data_w), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .instr_valid(ivalid_w), .instr_ready(iready_w), .instr(instr_w),
    .instr_pc(ipc_w), .fifo_count(fcount_w), .misalign_err(merr_w)
  );

  // Synchronous instruction memory models.
  always_ff @(posedge clk) begin
    if (rd_ena) rd_data <= addr ^ K;
    if (rd_ena_w) rd_data_w <= addr_w ^ K;
  end

  task automatic apply_reset();
    @(negedge clk);
    rstb = 1'b0;
    rstb_w = 1'b0;
    redir_v = 1'b0;
    redir_pc = 32'h0;
    iready = 1'b0;
    iready_w = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
  endtask

  task automatic test_reset();
    // Asynchronous assertion, before any clock edge has occurred.
    rstb = 1'b1;
    rstb_w = 1'b1;
    #1;
    rstb = 1'b0;
    rstb_w = 1'b0;
    #1;
    checks++; if (rd_ena !== 1'b0) begin errors++; $display("FAIL reset_rd_ena: got %b expected 0", rd_ena); end
    checks++; if (addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 00000000", addr); end
    checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ivalid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 00000000", instr); end
    checks++; if (ipc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 00000000", ipc); end
    checks++; if (fcount !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fcount); end
    checks++; if (merr !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", merr); end
    checks++; if (addr_w !== WRAP_PC) begin errors++; $display("FAIL reset_addr_w: got %h expected %h", addr_w, WRAP_PC); end
  endtask

  task automatic test_sequential();
    int first = -1;
    int nvalid = 0;
    logic [31:0] e;
    apply_reset();
    iready = 1'b1;
    rstb = 1'b1;
    for (int i = 0; i < 10; i++) exp_q.push_back(32'(i * 4));
    #1;
    checks++; if (rd_ena !== 1'b1) begin errors++; $display("FAIL seq_first_issue: got %b expected 1", rd_ena); end
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (ivalid) begin
        if (first < 0) first = cyc;
        nvalid++;
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL seq_extra: unexpected pc %h", ipc);
        end else begin
          e = exp_q.pop_front();
          checks++; if (ipc !== e) begin errors++; $display("FAIL seq_pc: got %h expected %h", ipc, e); end
          checks++; if (instr !== (e ^ K)) begin errors++; $display("FAIL seq_instr: got %h expected %h", instr, e ^ K); end
        end
      end
    end
    checks++; if (first != 2) begin errors++; $display("FAIL seq_first_valid: got cycle %0d expected 2", first); end
    checks++; if (nvalid != 10) begin errors++; $display("FAIL seq_throughput: got %0d pops expected 10", nvalid); end
  endtask

  task automatic test_backpressure();
    int reads = 0;
    logic [31:0] e;
    apply_reset();
    iready = 1'b0;
    rstb = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (rd_ena) reads++;
      if (ivalid) begin
        checks++; if (ipc !== 32'h0) begin errors++; $display("FAIL bp_hold_pc: got %h expected 00000000", ipc); end
      end
    end
    checks++; if (reads != 4) begin errors++; $display("FAIL bp_reads: got %0d expected 4", reads); end
    checks++; if (fcount !== 3'd4) begin errors++; $display("FAIL bp_count: got %0d expected 4", fcount); end
    checks++; if (rd_ena !== 1'b0) begin errors++; $display("FAIL bp_rd_ena: got %b expected 0", rd_ena); end
    @(negedge clk);
    iready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      checks++; if (ivalid !== 1'b1) begin errors++; $display("FAIL bp_gap: got valid %b expected 1 at pop %0d", ivalid, k); end
      if (ivalid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++; if (ipc !== e) begin errors++; $display("FAIL bp_pc: got %h expected %h", ipc, e); end
      end
    end
  endtask

  task automatic test_redirect_flush();
    int first = -1;
    logic [31:0] e;
    apply_reset();
    iready = 1'b0;
    rstb = 1'b1;
    repeat (4) @(negedge clk);
    // Cycle R = 4: three entries buffered, the fourth read in flight.
    checks++; if (fcount !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d expected 3", fcount); end
    redir_v = 1'b1;
    redir_pc = 32'h100;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    @(negedge clk);
    redir_v = 1'b0;
    iready = 1'b1;
    checks++; if (fcount !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", fcount); end
    checks++; if (addr !== 32'h100) begin errors++; $display("FAIL flush_addr: got %h expected 00000100", addr); end
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      if (ivalid) begin
        if (first < 0) first = k;
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL flush_extra: unexpected pc %h", ipc);
        end else begin
          e = exp_q.pop_front();
          checks++; if (ipc !== e) begin errors++; $display("FAIL flush_pc: got %h expected %h", ipc, e); end
        end
      end
    end
    checks++; if (first != 3) begin errors++; $display("FAIL flush_latency: got R+%0d expected R+3", first); end
  endtask

  task automatic test_redirect_handshake();
    int budget;
    logic [31:0] e;
    apply_reset();
    iready = 1'b1;
    rstb = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(32'(i * 4));
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (ivalid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++; if (ipc !== e) begin errors++; $display("FAIL hs_pc: got %h expected %h", ipc, e); end
      end
    end
    // Cycle 4: head pc 8 is popped in the same cycle as the redirect.
    redir_v = 1'b1;
    redir_pc = 32'h200;
    exp_q.push_back(32'h200);
    @(negedge clk);
    redir_v = 1'b0;
    checks++; if (fcount !== 3'd0) begin errors++; $display("FAIL hs_count: got %0d expected 0", fcount); end
    budget = 6;
    while (!ivalid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      checks++; errors++; $display("FAIL hs_timeout: got no valid expected pc 00000200");
    end else begin
      e = exp_q.pop_front();
      checks++; if (ipc !== e) begin errors++; $display("FAIL hs_next_pc: got %h expected %h", ipc, e); end
    end
  endtask

  task automatic test_misaligned();
    int budget;
    checks++; if (merr !== 1'b0) begin errors++; $display("FAIL mis_pre: got %b expected 0", merr); end
    @(negedge clk);
    redir_v = 1'b1;
    redir_pc = 32'h102;
    #1;
    checks++; if (rd_ena !== 1'b0) begin errors++; $display("FAIL mis_issue_suppress: got %b expected 0", rd_ena); end
    @(negedge clk);
    redir_v = 1'b0;
    checks++; if (merr !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b expected 1", merr); end
    checks++; if (addr !== 32'h100) begin errors++; $display("FAIL mis_addr: got %h expected 00000100", addr); end
    budget = 6;
    while (!ivalid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      checks++; errors++; $display("FAIL mis_timeout: got no valid expected pc 00000100");
    end else begin
      checks++; if (ipc !== 32'h100) begin errors++; $display("FAIL mis_pc: got %h expected 00000100", ipc); end
    end
    // An aligned redirect later must not clear the sticky flag.
    @(negedge clk);
    redir_v = 1'b1;
    redir_pc = 32'h300;
    @(negedge clk);
    redir_v = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (merr !== 1'b1) begin errors++; $display("FAIL mis_sticky: got %b expected 1", merr); end
    @(posedge clk);
    #2 rstb = 1'b0;
    #1;
    checks++; if (merr !== 1'b0) begin errors++; $display("FAIL mis_reset_clear: got %b expected 0", merr); end
  endtask

  task automatic test_wrap_async();
    logic [31:0] e;
    apply_reset();
    iready_w = 1'b1;
    rstb_w = 1'b1;
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0004);
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (ivalid_w && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++; if (ipc_w !== e) begin errors++; $display("FAIL wrap_pc: got %h expected %h", ipc_w, e); end
        checks++; if (instr_w !== (e ^ K)) begin errors++; $display("FAIL wrap_instr: got %h expected %h", instr_w, e ^ K); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_missing: got %0d unpopped expected 0", exp_q.size()); end
    @(posedge clk);
    #2;
    checks++; if (ivalid_w !== 1'b1) begin errors++; $display("FAIL async_pre_valid: got %b expected 1", ivalid_w); end
    rstb_w = 1'b0;
    #1;
    checks++; if (ivalid_w !== 1'b0) begin errors++; $display("FAIL async_valid: got %b expected 0", ivalid_w); end
    checks++; if (instr_w !== 32'h0) begin errors++; $display("FAIL async_instr: got %h expected 00000000", instr_w); end
    checks++; if (ipc_w !== 32'h0) begin errors++; $display("FAIL async_pc: got %h expected 00000000", ipc_w); end
    checks++; if (fcount_w !== 3'd0) begin errors++; $display("FAIL async_count: got %0d expected 0", fcount_w); end
    checks++; if (rd_ena_w !== 1'b0) begin errors++; $display("FAIL async_rd_ena: got %b expected 0", rd_ena_w); end
    checks++; if (addr_w !== WRAP_PC) begin errors++; $display("FAIL async_addr: got %h expected %h", addr_w, WRAP_PC); end
  endtask

  initial begin
    rstb = 1'b1;
    rstb_w = 1'b1;
    redir_v = 1'b0;
    redir_pc = 32'h0;
    iready = 1'b0;
    iready_w = 1'b0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_flush();
    test_redirect_handshake();
    test_misaligned();
    test_wrap_async();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
